// File: rtl/irq_pending.sv
// irq_pending: edge-detects request lines into masked pending bits and
// drives irq to the priority encoder consumer, with ack/overrun status.
// Ports: clk, rst_n, req, mask_we, mask_wdata, ack, ack_code ->
//        pend, irq, ovr, ack_err
module irq_pending #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic              mask_we,
  input  logic [WIDTH-1:0]  mask_wdata,
  input  logic              ack,
  input  logic [CODE_W-1:0] ack_code,
  output logic [WIDTH-1:0]  pend,
  output logic              irq,
  output logic [WIDTH-1:0]  ovr,
  output logic              ack_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t           state_q;
  logic             irq_q;
  logic             ack_err_q, ack_err_d;
  logic [WIDTH-1:0] req_q;
  logic [WIDTH-1:0] pnd_q, pnd_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ovr_q, ovr_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pend_w;
  logic             accept;
  logic             any_pend;

  assign rise     = req & ~req_q;
  assign pend_w   = pnd_q & ~mask_q;
  assign any_pend = |pend_w;

  assign accept = ack && (state_q == ACTIVE)
               && pend_w[ack_code];

  always_comb begin
    clr = '0;
    if (accept) begin
      clr[ack_code] = 1'b1;
    end
  end

  // A rise on a bit being cleared wins: the bit
  // stays pending and its overrun flag is frozen.
  always_comb begin
    pnd_d = (pnd_q & ~clr) | rise;
    ovr_d = (ovr_q & ~(clr & ~rise))
          | (rise & pnd_q & ~clr);
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_wdata;
    end
  end

  assign ack_err_d = ack && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      pnd_q     <= '0;
      mask_q    <= '0;
      ovr_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      req_q     <= req;
      pnd_q     <= pnd_d;
      mask_q    <= mask_d;
      ovr_q     <= ovr_d;
      ack_err_q <= ack_err_d;
    end
  end

  // HOLDOFF gives the encoder one settled cycle
  // before irq may re-assert from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_pend) begin
            state_q <= ACTIVE;
            irq_q   <= 1'b1;
          end else begin
            irq_q   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            state_q <= HOLDOFF;
            irq_q   <= 1'b0;
          end else if (!any_pend) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end else begin
            irq_q   <= 1'b1;
          end
        end
        HOLDOFF: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pend    = pend_w;
  assign irq     = irq_q;
  assign ovr     = ovr_q;
  assign ack_err = ack_err_q;

endmodule
